// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/writeback slice: opcode encodings in ALU
// mux order and the issue FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one write port,
// register 0 hard-wired to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REGS  = 8,
  parameter int AW    = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs_r [REGS];

  // Storage update; writes aimed at register 0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_r[raddr_a];
  assign rdata_b = (raddr_b == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_r[raddr_b];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue and writeback stage around an external ALU: accepts one instruction,
// reads operands, drives the ALU, writes back and returns the result.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OPERATION = 3,
  parameter int SHIFT     = 3,
  parameter int REGS      = 8,
  parameter int AW        = $clog2(REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERATION-1:0] in_op,
  input  logic [AW-1:0]        in_rd,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic [SHIFT-1:0]     in_shamt,
  input  logic                 in_carry,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [WIDTH-1:0]     ld_data,
  output logic [OPERATION-1:0] alu_operation,
  output logic [WIDTH-1:0]     alu_x,
  output logic [WIDTH-1:0]     alu_y,
  output logic [SHIFT-1:0]     alu_shamt,
  output logic                 alu_carry_in,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [AW-1:0]        out_rd,
  output logic                 out_zero,
  output logic                 out_overflow
);

  state_t               state_r, next_state_s;
  logic                 in_ready_s, accept_s, load_s;
  logic [AW-1:0]        rd_r, rs1_r, rs2_r;
  logic [OPERATION-1:0] alu_operation_r;
  logic [SHIFT-1:0]     alu_shamt_r;
  logic                 alu_carry_r;
  logic [WIDTH-1:0]     alu_x_r, alu_y_r, rdata_a_s, rdata_b_s;
  logic                 out_valid_r, out_zero_r, out_overflow_r;
  logic [WIDTH-1:0]     out_data_r;
  logic [AW-1:0]        out_rd_r;
  logic                 rf_we_s;
  logic [AW-1:0]        rf_waddr_s;
  logic [WIDTH-1:0]     rf_wdata_s;

  // Next-state decode; a pending load blocks acceptance in IDLE.
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = !ld_en;
        if (in_valid && !ld_en) next_state_s = ST_READ;
        else                    next_state_s = ST_IDLE;
      end
      ST_READ: next_state_s = ST_EXEC;
      ST_EXEC: next_state_s = ST_RESP;
      ST_RESP: begin
        if (out_ready) next_state_s = ST_IDLE;
        else           next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  assign accept_s = (state_r == ST_IDLE) && in_valid && !ld_en;
  assign load_s   = (state_r == ST_IDLE) && ld_en;

  // Shared write port: writeback in EXEC, otherwise direct loads from IDLE.
  always_comb begin
    if (state_r == ST_EXEC) begin
      rf_we_s    = 1'b1;
      rf_waddr_s = rd_r;
      rf_wdata_s = alu_result;
    end else begin
      rf_we_s    = load_s;
      rf_waddr_s = ld_addr;
      rf_wdata_s = ld_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Instruction latch, ALU drive registers and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_r            <= {AW{1'b0}};
      rs1_r           <= {AW{1'b0}};
      rs2_r           <= {AW{1'b0}};
      alu_operation_r <= {OPERATION{1'b0}};
      alu_shamt_r     <= {SHIFT{1'b0}};
      alu_carry_r     <= 1'b0;
      alu_x_r         <= {WIDTH{1'b0}};
      alu_y_r         <= {WIDTH{1'b0}};
      out_valid_r     <= 1'b0;
      out_data_r      <= {WIDTH{1'b0}};
      out_rd_r        <= {AW{1'b0}};
      out_zero_r      <= 1'b0;
      out_overflow_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        rd_r            <= in_rd;
        rs1_r           <= in_rs1;
        rs2_r           <= in_rs2;
        alu_operation_r <= in_op;
        alu_shamt_r     <= in_shamt;
        alu_carry_r     <= in_carry;
      end
      if (state_r == ST_READ) begin
        alu_x_r <= rdata_a_s;
        alu_y_r <= rdata_b_s;
      end
      if (state_r == ST_EXEC) begin
        out_valid_r    <= 1'b1;
        out_data_r     <= alu_result;
        out_rd_r       <= rd_r;
        out_zero_r     <= alu_zero;
        out_overflow_r <= alu_overflow;
      end else if ((state_r == ST_RESP) && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  alu_regfile #(
    .WIDTH (WIDTH),
    .REGS  (REGS),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we_s),
    .waddr   (rf_waddr_s),
    .wdata   (rf_wdata_s),
    .raddr_a (rs1_r),
    .rdata_a (rdata_a_s),
    .raddr_b (rs2_r),
    .rdata_b (rdata_b_s)
  );

  assign in_ready      = in_ready_s;
  assign alu_operation = alu_operation_r;
  assign alu_x         = alu_x_r;
  assign alu_y         = alu_y_r;
  assign alu_shamt     = alu_shamt_r;
  assign alu_carry_in  = alu_carry_r;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_rd        = out_rd_r;
  assign out_zero      = out_zero_r;
  assign out_overflow  = out_overflow_r;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural stand-in for the ALU.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic       clk, rst;
  logic       in_valid, in_ready, in_carry, ld_en;
  logic [2:0] in_op, in_rd, in_rs1, in_rs2, in_shamt, ld_addr;
  logic [7:0] ld_data;
  logic [2:0] alu_operation, alu_shamt;
  logic [7:0] alu_x, alu_y, alu_result;
  logic       alu_carry_in, alu_zero, alu_overflow;
  logic       out_valid, out_ready, out_zero, out_overflow;
  logic [7:0] out_data;
  logic [2:0] out_rd;
  logic [8:0] wide;
  int         checks, errors;

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_shamt(in_shamt), .in_carry(in_carry),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_operation(alu_operation), .alu_x(alu_x), .alu_y(alu_y),
    .alu_shamt(alu_shamt), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_zero(out_zero), .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in; overflow is the adder carry-out (borrow for SUB).
  always_comb begin
    alu_result   = 8'h00;
    alu_overflow = 1'b0;
    wide         = 9'h000;
    case (alu_operation)
      OP_AND: alu_result = alu_x & alu_y;
      OP_OR:  alu_result = alu_x | alu_y;
      OP_XOR: alu_result = alu_x ^ alu_y;
      OP_ADD: begin
        wide = {1'b0, alu_x} + {1'b0, alu_y} + {8'h00, alu_carry_in};
        alu_result = wide[7:0];
        alu_overflow = wide[8];
      end
      OP_SUB: begin
        wide = {1'b0, alu_x} - {1'b0, alu_y} - {8'h00, alu_carry_in};
        alu_result = wide[7:0];
        alu_overflow = wide[8];
      end
      OP_SLL: alu_result = alu_x << alu_shamt;
      OP_SRL: alu_result = alu_x >> alu_shamt;
      OP_SLT: alu_result = {7'h00, (alu_x < alu_y)};
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Present an instruction and return just after its accept edge.
  task automatic issue(input logic [2:0] op, rd, rs1, rs2, sh, input logic cin);
    int n;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_shamt = sh; in_carry = cin;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("issue_wait", 32'(n < 20), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [2:0] op, rd, rs1, rs2, sh,
                      input logic cin, input logic [7:0] ex, ey, ed,
                      input logic ez, eo);
    issue(op, rd, rs1, rs2, sh, cin);
    step();
    chk({tag, "_x"}, 32'(alu_x), 32'(ex));
    chk({tag, "_y"}, 32'(alu_y), 32'(ey));
    chk({tag, "_op"}, 32'(alu_operation), 32'(op));
    chk({tag, "_sh"}, 32'(alu_shamt), 32'(sh));
    chk({tag, "_cin"}, 32'(alu_carry_in), 32'(cin));
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
    chk({tag, "_zero"}, 32'(out_zero), 32'(ez));
    chk({tag, "_ovf"}, 32'(out_overflow), 32'(eo));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_done"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rd = 3'd0; in_rs1 = 3'd0;
    in_rs2 = 3'd0; in_shamt = 3'd0; in_carry = 1'b0; ld_en = 1'b0;
    ld_addr = 3'd0; ld_data = 8'h00; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_alu_x", 32'(alu_x), 32'd0);
    chk("rst_alu_op", 32'(alu_operation), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    rst = 1'b0;
    step();

    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'h0F;
    #1;
    chk("load_blocks_ready", 32'(in_ready), 32'd0);
    step();
    ld_en = 1'b0;
    load(3'd2, 8'h03);

    exec("add_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 3'd0, 1'b0, 8'h0F, 8'h03, 8'h12, 1'b0, 1'b0);
    exec("rd_r3", OP_OR, 3'd7, 3'd3, 3'd0, 3'd0, 1'b0, 8'h12, 8'h00, 8'h12, 1'b0, 1'b0);
    exec("sub_r4", OP_SUB, 3'd4, 3'd2, 3'd2, 3'd0, 1'b0, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0);
    exec("raw_r5", OP_ADD, 3'd5, 3'd4, 3'd1, 3'd0, 1'b0, 8'h00, 8'h0F, 8'h0F, 1'b0, 1'b0);
    exec("raw_r3", OP_ADD, 3'd3, 3'd3, 3'd2, 3'd0, 1'b0, 8'h12, 8'h03, 8'h15, 1'b0, 1'b0);
    exec("raw_rd3", OP_XOR, 3'd6, 3'd3, 3'd0, 3'd0, 1'b0, 8'h15, 8'h00, 8'h15, 1'b0, 1'b0);

    load(3'd1, 8'hFF);
    exec("add_ovf", OP_ADD, 3'd6, 3'd1, 3'd1, 3'd0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    exec("add_r0", OP_ADD, 3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 8'hFF, 8'h03, 8'h02, 1'b0, 1'b1);
    exec("rd_r0", OP_OR, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    load(3'd0, 8'h55);
    exec("ld_r0", OP_OR, 3'd7, 3'd0, 3'd2, 3'd0, 1'b0, 8'h00, 8'h03, 8'h03, 1'b0, 1'b0);
    exec("sll", OP_SLL, 3'd7, 3'd2, 3'd0, 3'd4, 1'b0, 8'h03, 8'h00, 8'h30, 1'b0, 1'b0);
    exec("srl", OP_SRL, 3'd7, 3'd1, 3'd0, 3'd3, 1'b0, 8'hFF, 8'h00, 8'h1F, 1'b0, 1'b0);
    exec("slt", OP_SLT, 3'd7, 3'd2, 3'd1, 3'd0, 1'b0, 8'h03, 8'hFF, 8'h01, 1'b0, 1'b0);

    // Backpressure with a second instruction waiting.
    issue(OP_AND, 3'd7, 3'd1, 3'd2, 3'd0, 1'b0);
    step(); step();
    chk("bp_first", 32'(out_data), 32'h03);
    in_valid = 1'b1; in_op = OP_XOR; in_rd = 3'd4; in_rs1 = 3'd1; in_rs2 = 3'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h03);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("bp_accepted", 32'(in_ready), 32'd0);
    step();
    chk("bp2_early", 32'(out_valid), 32'd0);
    chk("bp2_x", 32'(alu_x), 32'hFF);
    step();
    chk("bp2_valid", 32'(out_valid), 32'd1);
    chk("bp2_data", 32'(out_data), 32'hFC);
    chk("bp2_rd", 32'(out_rd), 32'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while the ADD sits in EXEC.
    issue(OP_ADD, 3'd5, 3'd1, 3'd2, 3'd0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("rst_exec_valid", 32'(out_valid), 32'd0);
    chk("rst_exec_data", 32'(out_data), 32'h00);
    chk("rst_exec_x", 32'(alu_x), 32'h00);
    chk("rst_exec_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    exec("post_rst", OP_OR, 3'd7, 3'd5, 3'd1, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

    // Load and instruction offered together: only the load happens.
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 8'h5A;
    in_valid = 1'b1; in_op = OP_ADD; in_rd = 3'd3; in_rs1 = 3'd2; in_rs2 = 3'd0;
    in_shamt = 3'd0; in_carry = 1'b0;
    #1;
    chk("ld_vs_issue_ready", 32'(in_ready), 32'd0);
    step();
    ld_en = 1'b0;
    #1;
    chk("ld_vs_issue_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    step();
    chk("ld_vs_issue_x", 32'(alu_x), 32'h5A);
    step();
    chk("ld_vs_issue_valid", 32'(out_valid), 32'd1);
    chk("ld_vs_issue_data", 32'(out_data), 32'h5A);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
